// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC expansion-bus initiator: op codes, FSM states,
// the bank-select port constants and the bank-write decode rule.
package cpc_bus_pkg;

  typedef enum logic [1:0] {
    OP_MEM_RD = 2'b00,
    OP_MEM_WR = 2'b01,
    OP_IO_WR  = 2'b10,
    OP_BANK   = 2'b11
  } cpc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TWIO = 3'd3,
    ST_TW   = 3'd4,
    ST_T3   = 3'd5
  } cpc_state_e;

  localparam logic [15:0] BANK_PORT_ADR   = 16'h7F00;
  localparam logic [1:0]  BANK_CMD_PREFIX = 2'b11;

  // The RAM expansion CPLD only decodes A15 low and a 0b11xxxxxx data byte.
  function automatic logic bank_write_hit(input logic [15:0] adr, input logic [7:0] wdata);
    return (adr[15] == 1'b0) && (wdata[7:6] == BANK_CMD_PREFIX);
  endfunction

endpackage

// File: rtl/cpc_wait_timer.sv
// Saturating wait-state counter; o_expired flags that the current TW cycle is
// the LIMIT-th one, so a still-low ready on this cycle ends the bus cycle.
module cpc_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count >= 8'(LIMIT - 1));

endmodule

// File: rtl/cpc_bus_initiator.sv
// CPC expansion-bus initiator: runs one Z80-style bus cycle per accepted request
// and shadows the last bank-select value written to the RAM expansion.
module cpc_bus_initiator
  import cpc_bus_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset_b,
  // A request transfers on a rising edge where req_valid and req_ready are both high;
  // req_ready is high only in IDLE; rsp_valid is a one-cycle pulse with no back-pressure.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [5:0]  req_bank,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        ramrd_b,
  input  logic        ready,
  output logic [5:0]  bank_q,
  output cpc_state_e  o_dbg_state
);

  cpc_state_e  r_state;
  cpc_state_e  w_next;
  cpc_op_e     r_op;
  logic [15:0] r_adr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rsp_rdata;
  logic [5:0]  r_bank;
  logic        r_err;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        w_accept;
  logic        w_is_io;
  logic        w_is_rd;
  logic        w_strobe_act;
  logic        w_expired;
  logic        w_timeout;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_is_io      = (r_op == OP_IO_WR) || (r_op == OP_BANK);
  assign w_is_rd      = (r_op == OP_MEM_RD);
  assign w_strobe_act = (r_state == ST_T2) || (r_state == ST_TWIO) ||
                        (r_state == ST_TW) || (r_state == ST_T3);
  assign w_timeout    = (r_state == ST_TW) && !ready && w_expired;

  cpc_wait_timer #(.LIMIT(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .reset_b   (reset_b),
    .i_clear   (r_state == ST_T1),
    .i_enable  (r_state == ST_TW),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = w_is_io ? ST_TWIO : (ready ? ST_T3 : ST_TW);
      ST_TWIO: w_next = ready ? ST_T3 : ST_TW;
      ST_TW:   if (ready || w_expired) w_next = ST_T3;
      ST_T3:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset releases them at once.
  always_comb begin
    mreq_b  = 1'b1;
    iorq_b  = 1'b1;
    rd_b    = 1'b1;
    wr_b    = 1'b1;
    ramrd_b = 1'b1;
    if (w_strobe_act) begin
      if (w_is_io) begin
        iorq_b = 1'b0;
        wr_b   = 1'b0;
      end else begin
        mreq_b = 1'b0;
        if (w_is_rd) begin
          rd_b    = 1'b0;
          ramrd_b = 1'b0;
        end else begin
          wr_b = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_op        <= OP_MEM_RD;
      r_adr       <= 16'h0000;
      r_wdata     <= 8'h00;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_bank      <= 6'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_op    <= cpc_op_e'(req_op);
        r_err   <= 1'b0;
        if (cpc_op_e'(req_op) == OP_BANK) begin
          r_adr   <= BANK_PORT_ADR;
          r_wdata <= {BANK_CMD_PREFIX, req_bank};
        end else begin
          r_adr   <= req_addr;
          r_wdata <= req_wdata;
        end
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_T3) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_is_rd ? data_in : 8'h00;
        r_rsp_err   <= r_err;
        if (w_is_io && bank_write_hit(r_adr, r_wdata)) begin
          r_bank <= r_wdata[5:0];
        end
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign data_oe     = (r_state != ST_IDLE) && !w_is_rd;
  assign adr         = r_adr;
  assign data_out    = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign bank_q      = r_bank;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: a cycle-timeline model fills an expected
// queue that a negedge compare process drains, plus hand-computed literal pins.
module tb_cpc_bus_initiator;
  import cpc_bus_pkg::*;

  localparam int unsigned WMAX = 4;

  typedef struct packed {
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        req_ready;
    logic [4:0]  strb;       // {mreq_b, iorq_b, rd_b, wr_b, ramrd_b}
    logic        data_oe;
    logic        chk_bus;
    logic [15:0] adr;
    logic        chk_dout;
    logic [7:0]  data_out;
    logic [5:0]  bank_q;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [5:0]  req_bank;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] adr;
  logic [7:0]  data_out, data_in;
  logic        data_oe, mreq_b, iorq_b, rd_b, wr_b, ramrd_b, ready;
  logic [5:0]  bank_q;
  cpc_state_e  dbg_state;

  cpc_bus_initiator #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bank(req_bank),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr(adr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .ramrd_b(ramrd_b),
    .ready(ready), .bank_q(bank_q), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [5:0] m_bank = 6'd0;
  logic       pend_v = 1'b0;
  logic       pend_err = 1'b0;
  logic [7:0] pend_rdata = 8'h00;
  int t_acc = 0;

  // ---------------- monitor ----------------
  int cyc = 0;
  int n_mreq = 0, n_iorq = 0, n_rd = 0, n_wr = 0, n_ramrd = 0, n_oe = 0;
  int n_rsp = 0, n_b2b = 0, n_overlap = 0, rsp_cyc = 0;
  logic [7:0]  rsp_rd = 8'h00;
  logic        rsp_e = 1'b0;
  logic [5:0]  rsp_bank = 6'd0;
  logic [15:0] cap_adr = 16'h0000;
  logic [7:0]  cap_dout = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mreq_b)  n_mreq++;
    if (!iorq_b)  n_iorq++;
    if (!rd_b)    n_rd++;
    if (!wr_b)    n_wr++;
    if (!ramrd_b) n_ramrd++;
    if (data_oe) begin
      n_oe++;
      cap_adr  = adr;
      cap_dout = data_out;
    end
    if (rsp_valid) begin
      n_rsp++;
      rsp_cyc  = cyc;
      rsp_rd   = rsp_rdata;
      rsp_e    = rsp_err;
      rsp_bank = bank_q;
    end
    if (rsp_valid && req_valid && req_ready) n_b2b++;
    if ((!mreq_b && !iorq_b) || (!rd_b && !wr_b)) n_overlap++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  exp_t ce;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_t'(exp_q.pop_front());
      check("ctrl", {24'd0, rsp_valid, req_ready, mreq_b, iorq_b, rd_b, wr_b, ramrd_b, data_oe},
            {24'd0, ce.rsp_valid, ce.req_ready, ce.strb, ce.data_oe});
      check("bank_q", {26'd0, bank_q}, {26'd0, ce.bank_q});
      if (ce.rsp_valid) begin
        check("rsp", {23'd0, rsp_err, rsp_rdata}, {23'd0, ce.rsp_err, ce.rsp_rdata});
      end
      if (ce.chk_bus) check("adr", {16'd0, adr}, {16'd0, ce.adr});
      if (ce.chk_dout) check("data_out", {24'd0, data_out}, {24'd0, ce.data_out});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle();
    exp_t e;
    e = '0;
    e.rsp_valid = pend_v;
    e.rsp_err   = pend_err;
    e.rsp_rdata = pend_rdata;
    e.req_ready = 1'b1;
    e.strb      = 5'b11111;
    e.bank_q    = m_bank;
    exp_q.push_back(e);
    pend_v = 1'b0;
  endtask

  task automatic idle_cycle();
    next_cycle();
    req_valid = 1'b0;
    ready     = 1'b1;
    push_idle();
  endtask

  // nwait = number of consecutive ready=0 samples starting at the first point
  // the bus cycle looks at ready (end of T2 for memory, end of TWIO for I/O).
  task automatic txn(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                     input logic [5:0] bank, input logic [7:0] rdata, input int nwait,
                     input bit hold);
    exp_t e;
    logic [15:0] a;
    logic [7:0]  d;
    bit io, wr, rd, err;
    int tw, len, first;
    a   = (op == 2'b11) ? 16'h7F00 : addr;
    d   = (op == 2'b11) ? {2'b11, bank} : wd;
    io  = op[1];
    rd  = (op == 2'b00);
    wr  = !rd;
    tw  = (nwait < int'(WMAX)) ? nwait : int'(WMAX);
    err = (nwait > int'(WMAX));
    len = 3 + (io ? 1 : 0) + tw;
    first = io ? 2 : 1;
    next_cycle();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_bank  = bank;
    data_in   = rdata;
    ready     = 1'b1;
    t_acc     = cyc;
    push_idle();
    for (int c = 0; c < len; c++) begin
      next_cycle();
      req_valid = hold;
      ready = !(c >= first && c < first + nwait);
      e = '0;
      e.strb     = (c == 0) ? 5'b11111 : {io, !io, !rd, !wr, !rd};
      e.data_oe  = wr;
      e.chk_bus  = 1'b1;
      e.adr      = a;
      e.chk_dout = wr;
      e.data_out = d;
      e.bank_q   = m_bank;
      exp_q.push_back(e);
    end
    pend_v     = 1'b1;
    pend_err   = err;
    pend_rdata = rd ? rdata : 8'h00;
    if (io && bank_write_hit(a, d)) m_bank = d[5:0];
  endtask

  int b_mreq, b_iorq, b_rd, b_wr, b_ramrd, b_oe, b_rsp, b_b2b;
  task automatic snap();
    b_mreq = n_mreq; b_iorq = n_iorq; b_rd = n_rd; b_wr = n_wr;
    b_ramrd = n_ramrd; b_oe = n_oe; b_rsp = n_rsp; b_b2b = n_b2b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = 8'h0;
    req_bank = 6'd0; data_in = 8'h0; ready = 1'b1;
    #12;
    check("rst_strobes", {27'd0, mreq_b, iorq_b, rd_b, wr_b, ramrd_b}, 32'h1F);
    check("rst_oe_rsp", {29'd0, data_oe, rsp_valid, rsp_err}, 32'h0);
    check("rst_adr_dout", {8'd0, adr, data_out}, 32'h0);
    check("rst_rdata_bank", {18'd0, rsp_rdata, bank_q}, 32'h0);
    @(negedge clk);
    reset_b = 1'b1;
    next_cycle();
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // memory read, no waits
    snap();
    txn(2'b00, 16'h4000, 8'h00, 6'd0, 8'hA5, 0, 0);
    idle_cycle(); idle_cycle();
    check("rd_mreq_lo", 32'(n_mreq - b_mreq), 32'd2);
    check("rd_rd_lo", 32'(n_rd - b_rd), 32'd2);
    check("rd_ramrd_lo", 32'(n_ramrd - b_ramrd), 32'd2);
    check("rd_latency", 32'(rsp_cyc - t_acc - 1), 32'd3);
    check("rd_rdata", {24'd0, rsp_rd}, 32'hA5);
    check("rd_err", {31'd0, rsp_e}, 32'd0);

    // memory write with three wait samples
    snap();
    txn(2'b01, 16'hC123, 8'h3C, 6'd0, 8'h00, 3, 0);
    idle_cycle(); idle_cycle();
    check("wr_wr_lo", 32'(n_wr - b_wr), 32'd5);
    check("wr_oe_hi", 32'(n_oe - b_oe), 32'd6);
    check("wr_rd_lo", 32'(n_rd - b_rd), 32'd0);
    check("wr_latency", 32'(rsp_cyc - t_acc - 1), 32'd6);

    // bank select, then an I/O write that must not touch the shadow
    snap();
    txn(2'b11, 16'hFFFF, 8'h00, 6'b001010, 8'h00, 0, 0);
    idle_cycle(); idle_cycle();
    check("bank_iorq_lo", 32'(n_iorq - b_iorq), 32'd3);
    check("bank_adr", {16'd0, cap_adr}, 32'h7F00);
    check("bank_dout", {24'd0, cap_dout}, 32'hCA);
    check("bank_shadow", {26'd0, rsp_bank}, 32'h0A);
    check("bank_latency", 32'(rsp_cyc - t_acc - 1), 32'd4);
    txn(2'b10, 16'h7F00, 8'h40, 6'd0, 8'h00, 0, 0);
    idle_cycle(); idle_cycle();
    check("io40_shadow", {26'd0, rsp_bank}, 32'h0A);
    txn(2'b10, 16'h8123, 8'hC5, 6'd0, 8'h00, 0, 0);
    idle_cycle();
    txn(2'b10, 16'h3F00, 8'hD7, 6'd0, 8'h00, 2, 0);
    idle_cycle(); idle_cycle();
    check("io_shadow", {26'd0, rsp_bank}, 32'h17);
    check("io_wait_latency", 32'(rsp_cyc - t_acc - 1), 32'd6);

    // wait boundary and timeout
    txn(2'b00, 16'h2000, 8'h00, 6'd0, 8'h81, 4, 0);
    idle_cycle(); idle_cycle();
    check("w4_err", {31'd0, rsp_e}, 32'd0);
    check("w4_latency", 32'(rsp_cyc - t_acc - 1), 32'd7);
    snap();
    txn(2'b00, 16'h1234, 8'h00, 6'd0, 8'h5E, 10, 0);
    idle_cycle(); idle_cycle();
    check("to_rd_lo", 32'(n_rd - b_rd), 32'd6);
    check("to_latency", 32'(rsp_cyc - t_acc - 1), 32'd7);
    check("to_err", {31'd0, rsp_e}, 32'd1);
    check("to_rdata", {24'd0, rsp_rd}, 32'h5E);
    txn(2'b00, 16'h1235, 8'h00, 6'd0, 8'h00, 5, 0);
    idle_cycle();
    txn(2'b00, 16'h1236, 8'h00, 6'd0, 8'h6B, 0, 0);
    idle_cycle(); idle_cycle();
    check("after_to_err", {31'd0, rsp_e}, 32'd0);

    // back-to-back with req_valid held high
    snap();
    txn(2'b01, 16'h0010, 8'h77, 6'd0, 8'h00, 0, 1);
    txn(2'b00, 16'h0020, 8'h00, 6'd0, 8'h99, 1, 0);
    idle_cycle(); idle_cycle();
    check("b2b_accept", 32'(n_b2b - b_b2b), 32'd1);
    check("b2b_rsp_count", 32'(n_rsp - b_rsp), 32'd2);

    // reset during TW of a read
    snap();
    next_cycle();
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h5555; data_in = 8'h11; ready = 1'b0;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    check("pre_rst_mreq", {31'd0, mreq_b}, 32'd0);
    reset_b = 1'b0;
    #1;
    check("mid_rst_strobes", {27'd0, mreq_b, iorq_b, rd_b, wr_b, ramrd_b}, 32'h1F);
    check("mid_rst_rsp_oe", {30'd0, rsp_valid, data_oe}, 32'd0);
    check("mid_rst_bank", {26'd0, bank_q}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_b = 1'b1;
    ready = 1'b1;
    next_cycle();
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    next_cycle();
    check("abort_no_rsp", 32'(n_rsp - b_rsp), 32'd0);
    m_bank = 6'd0;
    pend_v = 1'b0;
    txn(2'b00, 16'h0001, 8'h00, 6'd0, 8'h3A, 0, 0);
    idle_cycle(); idle_cycle();
    check("recover_rdata", {24'd0, rsp_rd}, 32'h3A);

    idle_cycle();
    next_cycle();
    check("strobe_overlap", 32'(n_overlap), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Synchronous Z80-style bus initiator that turns single-beat requests into CPC expansion-bus cycles: memory read, memory write, I/O write, and the bank-select write to &7Fxx with 0b11cccbbb that the RAM expansion CPLD decodes. It is the host end of the expansion protocol and sits between a request source (bench sequencer or FPGA host core) and the CPC bus pins. It keeps a shadow of the last bank-select value written, so software and scoreboards know the active mapping without a readback path.

## Interface
- WAIT_MAX, 255: max consecutive wait states (TW) before a cycle is aborted with error; 1..255.
- clk  in  1  bus clock; one state per rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept; high only in IDLE.
- req_op  in  2  00 mem read, 01 mem write, 10 I/O write, 11 bank select.
- req_addr  in  16  address; ignored for op 11.
- req_wdata  in  8  write data; ignored for ops 00 and 11.
- req_bank  in  6  cccbbb for op 11.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid for op 00, else 0.
- rsp_err  out  1  wait timeout; valid with rsp_valid.
- adr  out  16  bus address.
- data_out  out  8  bus write data.
- data_oe  out  1  drive enable for data_out.
- data_in  in  8  bus read data.
- mreq_b, iorq_b, rd_b, wr_b, ramrd_b  out  1 each  active-low bus strobes.
- ready  in  1  bus ready; 0 requests a wait state.
- bank_q  out  6  shadow of the last bank value decoded from a completed I/O write.

## Operation
- States: IDLE, T1, T2, TWIO, TW, T3.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata/bank and go to T1.
- Op 11 latches addr=16'h7F00 and wdata={2'b11,req_bank}, then runs as an I/O write.
- T1: adr driven; all strobes high; data_oe=1 for writes. Next state is T2.
- T2: memory read drives mreq_b=0, rd_b=0, ramrd_b=0. Memory write drives mreq_b=0, wr_b=0. I/O write drives iorq_b=0, wr_b=0.
- Leaving T2: I/O goes to TWIO, the mandatory wait. Memory goes to T3 if ready=1, else TW.
- TWIO: strobes held. Goes to T3 if ready=1, else TW.
- TW: strobes held; wait counter increments each cycle. Goes to T3 when ready=1. If the counter reaches WAIT_MAX with ready still 0, set the error flag and go to T3.
- T3: strobes held. On the exit edge, data_in is captured for reads. Next state is IDLE with rsp_valid=1 that cycle and strobes high.
- Shadow update: on T3 exit of an I/O write with adr[15]=0 and wdata[7:6]=11, bank_q <= wdata[5:0]. Ops 10 and 11 use the same rule.
- adr, data_out and data_oe are constant from T1 through T3. data_oe=0 in IDLE.
- At most one strobe group is active at a time: never mreq_b and iorq_b low together, never rd_b and wr_b low together.
- The wait counter clears in T1.

## Timing
- Reset values: state IDLE; all strobes 1; data_oe 0; adr 0; data_out 0; rsp_valid 0; rsp_rdata 0; rsp_err 0; bank_q 0; req_ready 1 once reset_b is released.
- Reset mid-cycle forces all strobes high asynchronously. No rsp_valid is emitted for the aborted request.
- Memory op, no waits: accept edge E0. T1 is E0..E1, T2 E1..E2, T3 E2..E3, rsp_valid E3..E4. Next accept at E4.
- Each ready=0 sampled at the end of T2 or TW adds one cycle.
- I/O op, no waits: one cycle longer than a memory op (TWIO), so rsp_valid at E4..E5.
- Timeout: T3 is entered after WAIT_MAX TW cycles; rsp_err=1, and rsp_rdata=data_in as sampled.
- rsp_valid coincides with req_ready=1, so a new request can be accepted in the same cycle as the response.

## Structure
- Shared package `cpc_bus_pkg`:
  - op encodings
  - state enum
  - BANK_PORT_ADR = 16'h7F00
  - BANK_CMD_PREFIX = 2'b11
  - the I/O bank-write decode function, also used by the bench scoreboard
- One sub-module, `cpc_wait_timer`: 8-bit saturating counter with clear/enable inputs and an expired output.

## Test plan
- Memory read of &4000 with ready=1 and data_in=&A5: mreq_b/rd_b/ramrd_b low for exactly 2 cycles; rsp_valid 3 cycles after accept; rsp_rdata=&A5; rsp_err=0.
- Memory write of &C123 with data &3C and ready low for 3 cycles at T2: wr_b low for 5 cycles; data_oe high for 6 cycles; rd_b stays high; rsp_valid 6 cycles after accept.
- Bank select with req_bank=6'b001010: adr=&7F00, data_out=&CA, iorq_b low for 3 cycles; bank_q=&0A at rsp_valid. A following I/O write of &40 to &7F00 leaves bank_q unchanged.
- Timeout with WAIT_MAX=4 and ready held low: exactly 4 TW cycles, then T3; rsp_err=1; the next request completes normally with rsp_err=0.
- Reset asserted during TW of a read: strobes go high immediately with no rsp_valid; bank_q=0; req_ready=1 on the first edge after release.
- Back-to-back: a write then a read issued with req_valid held high: second accept in the same cycle as the first rsp_valid; no cycle has mreq_b and iorq_b low together.
